// File: rtl/key_step_debouncer_pkg.sv
// rtl/key_step_debouncer_pkg.sv - State encoding and default timing for the step-key debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } key_state_t;

  // Defaults assume CLOCK_50: 10 ms debounce, 0.5 s first repeat, 0.1 s repeat period.
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam bit DEF_REPEAT_EN       = 1'b1;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_step_debouncer_if.sv
// rtl/key_step_debouncer_if.sv - Raw key input and debounced pulse/level/count outputs.
interface key_step_debouncer_if;
  logic       key_in;
  logic       pulse;
  logic       held;
  logic [7:0] press_count;

  modport master (output key_in, input pulse, input held, input press_count);
  modport slave  (input key_in, output pulse, output held, output press_count);
endinterface

// File: rtl/key_step_debouncer_sync_chain.sv
// rtl/key_step_debouncer_sync_chain.sv - Multi-flop synchronizer resetting to the released level.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] flops;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) flops <= '1;
    else       flops <= {flops[STAGES-2:0], d};
  end

  assign q = flops[STAGES-1];
endmodule

// File: rtl/key_step_debouncer.sv
// rtl/key_step_debouncer.sv - Debounces an active-low key into one pulse per press plus auto-repeat.
module key_step_debouncer
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic                 Clock,
  input logic                 Reset,
  key_step_debouncer_if.slave bus
);
  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEB_C    = cnt_t'(DEBOUNCE_CYCLES);
  localparam cnt_t DELAY_C  = cnt_t'(REPEAT_DELAY);
  localparam cnt_t PERIOD_C = cnt_t'(REPEAT_PERIOD);

  logic       sync_q;
  logic       pressed_s;
  key_state_t state, next_state;
  cnt_t       deb_cnt, deb_cnt_d, deb_inc;
  cnt_t       rpt_cnt, rpt_cnt_d, rpt_inc, rpt_target;
  logic       rpt_phase, rpt_phase_d;
  logic       pulse_q, pulse_d;
  logic       held_q, held_d;
  logic [7:0] count_q, count_d;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .Clock (Clock),
    .Reset (Reset),
    .d     (bus.key_in),
    .q     (sync_q)
  );

  assign pressed_s = ~sync_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
      pulse_q   <= 1'b0;
      held_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state     <= next_state;
      deb_cnt   <= deb_cnt_d;
      rpt_cnt   <= rpt_cnt_d;
      rpt_phase <= rpt_phase_d;
      pulse_q   <= pulse_d;
      held_q    <= held_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (pressed_s) next_state = PRESS_CHK;
      PRESS_CHK:   if (!pressed_s) next_state = IDLE;
                   else if (deb_cnt >= DEB_C) next_state = HELD;
      HELD:        if (!pressed_s) next_state = RELEASE_CHK;
      RELEASE_CHK: if (pressed_s) next_state = HELD;
                   else if (deb_cnt >= DEB_C) next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // rpt_phase=0 waits for the first repeat after REPEAT_DELAY, then REPEAT_PERIOD spacing.
  always_comb begin
    deb_cnt_d   = deb_cnt;
    rpt_cnt_d   = rpt_cnt;
    rpt_phase_d = rpt_phase;
    pulse_d     = 1'b0;
    deb_inc     = (deb_cnt == '1) ? deb_cnt : deb_cnt + cnt_t'(1);
    rpt_inc     = (rpt_cnt == '1) ? rpt_cnt : rpt_cnt + cnt_t'(1);
    rpt_target  = rpt_phase ? PERIOD_C : DELAY_C;
    case (state)
      IDLE: deb_cnt_d = '0;
      PRESS_CHK: begin
        if (next_state == HELD) begin
          pulse_d     = 1'b1;
          deb_cnt_d   = '0;
          rpt_cnt_d   = '0;
          rpt_phase_d = 1'b0;
        end else if (next_state == IDLE) begin
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      HELD: begin
        if (next_state == RELEASE_CHK) begin
          deb_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_inc;
          if (REPEAT_EN && rpt_inc == rpt_target) begin
            pulse_d     = 1'b1;
            rpt_cnt_d   = '0;
            rpt_phase_d = 1'b1;
          end
        end
      end
      RELEASE_CHK: deb_cnt_d = (next_state == RELEASE_CHK) ? deb_inc : '0;
      default:     deb_cnt_d = '0;
    endcase
    held_d  = (next_state == HELD) || (next_state == RELEASE_CHK);
    count_d = count_q + 8'(pulse_d);
  end

  assign bus.pulse       = pulse_q;
  assign bus.held        = held_q;
  assign bus.press_count = count_q;
endmodule
